// File: rtl/imm_instr_encoder_pkg.sv
// Shared types and helpers for the RV32 immediate instruction encoder:
// format codes, the substitute NOP word, field packers and the immediate range check.
package imm_instr_encoder_pkg;

   typedef enum logic [1:0] {
      FMT_I = 2'b00,
      FMT_S = 2'b01,
      FMT_B = 2'b11
   } fmt_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic [31:0] pack_i(input logic [11:0] imm,
                                          input logic [4:0]  rs1,
                                          input logic [2:0]  funct3,
                                          input logic [4:0]  rd,
                                          input logic [6:0]  opcode);
      return {imm[11:0], rs1, funct3, rd, opcode};
   endfunction

   function automatic logic [31:0] pack_s(input logic [11:0] imm,
                                          input logic [4:0]  rs2,
                                          input logic [4:0]  rs1,
                                          input logic [2:0]  funct3,
                                          input logic [6:0]  opcode);
      return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
   endfunction

   // imm holds bits [12:1] of the byte offset; bit 0 is known zero for B-format.
   function automatic logic [31:0] pack_b(input logic [12:1] imm,
                                          input logic [4:0]  rs2,
                                          input logic [4:0]  rs1,
                                          input logic [2:0]  funct3,
                                          input logic [6:0]  opcode);
      return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
   endfunction

   // hi = imm[31:11]; lsb = imm[0]. Returns 1 when the immediate cannot be encoded.
   function automatic logic imm_err(input fmt_e        fmt,
                                    input logic [20:0] hi,
                                    input logic        lsb);
      case (fmt)
         FMT_I, FMT_S: return !((&hi) || !(|hi));
         FMT_B:        return lsb || !((&hi[20:1]) || !(|hi[20:1]));
         default:      return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/imm_instr_encoder.sv
// Two-stage streaming encoder: stage 1 registers fields and range-checks the immediate,
// stage 2 packs the RV32 word (or a NOP on error) and tracks its byte address.
module imm_instr_encoder
   import imm_instr_encoder_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           opcode,
   input  logic [4:0]           rd,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   input  logic [2:0]           funct3,
   input  logic [31:0]          imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [ADDR_W-1:0]    BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0]    WORD_STEP = ADDR_W'(4);
   localparam logic [ERR_CNT_W-1:0] CNT_ONE   = ERR_CNT_W'(1);

   // Valid/ready: a word moves across a boundary on the clock edge where the sender's
   // valid and the receiver's ready are both high; a sender holding valid keeps its
   // payload stable until that edge, and valid never drops before the transfer.

   logic        s1_valid;
   logic        s1_err;
   logic [6:0]  s1_opcode;
   logic [4:0]  s1_rd;
   logic [4:0]  s1_rs1;
   logic [4:0]  s1_rs2;
   logic [2:0]  s1_funct3;
   logic [12:0] s1_imm;

   logic        s1_advance;
   logic        out_fire;
   logic [31:0] s2_word;

   assign s1_advance = !out_valid || out_ready;
   assign in_ready   = !s1_valid || s1_advance;
   assign out_fire   = out_valid && out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_err    <= 1'b0;
         s1_opcode <= '0;
         s1_rd     <= '0;
         s1_rs1    <= '0;
         s1_rs2    <= '0;
         s1_funct3 <= '0;
         s1_imm    <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_err    <= imm_err(fmt_e'(opcode[6:5]), imm[31:11], imm[0]);
            s1_opcode <= opcode;
            s1_rd     <= rd;
            s1_rs1    <= rs1;
            s1_rs2    <= rs2;
            s1_funct3 <= funct3;
            s1_imm    <= imm[12:0];
         end
      end
   end

   // Only bits [12:0] of the immediate survive stage 1; the range check already
   // guaranteed the upper bits are a pure sign extension.
   always_comb begin
      s2_word = NOP_INSTR;
      if (!s1_err) begin
         case (fmt_e'(s1_opcode[6:5]))
            FMT_I:   s2_word = pack_i(s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode);
            FMT_S:   s2_word = pack_s(s1_imm[11:0], s1_rs2, s1_rs1, s1_funct3, s1_opcode);
            FMT_B:   s2_word = pack_b(s1_imm[12:1], s1_rs2, s1_rs1, s1_funct3, s1_opcode);
            default: s2_word = NOP_INSTR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
      end else if (s1_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_instr <= s2_word;
            out_err   <= s1_err;
         end
      end
   end

   // clear overrides the post-handshake update; the word leaving this cycle
   // already carried its address on out_addr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_addr  <= BASE;
         err_count <= '0;
      end else if (clear) begin
         out_addr  <= BASE;
         err_count <= '0;
      end else if (out_fire) begin
         out_addr <= out_addr + WORD_STEP;
         if (out_err && !(&err_count)) begin
            err_count <= err_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder: directed test-plan steps followed by randomized traffic,
// checked against an arithmetic encoding model and an address/error-count model.
module tb_imm_instr_encoder;

   localparam int ADDR_W    = 4;
   localparam int BASE_ADDR = 0;
   localparam int ERR_CNT_W = 3;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic                 clk;
   logic                 reset;
   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [6:0]           opcode;
   logic [4:0]           rd;
   logic [4:0]           rs1;
   logic [4:0]           rs2;
   logic [2:0]           funct3;
   logic [31:0]          imm;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_instr;
   logic [ADDR_W-1:0]    out_addr;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_count;

   imm_instr_encoder #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .ERR_CNT_W (ERR_CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .out_err   (out_err),
      .err_count (err_count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int acc_cnt = 0;

   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   logic [31:0] exp_imm_q[$];

   int          m_addr = BASE_ADDR;
   int          m_cnt  = 0;
   logic        stalled = 1'b0;
   logic        prev_clear = 1'b0;
   logic [31:0] st_instr;
   logic [ADDR_W-1:0] st_addr;
   logic        st_err;

   logic [31:0] edge_imm [10] = '{32'hFFFF_EFFF, 32'hFFFF_F000, 32'hFFFF_F7FF, 32'hFFFF_F800,
                                  32'h0000_07FF, 32'h0000_0800, 32'h0000_0FFE, 32'h0000_0FFF,
                                  32'hFFFF_F001, 32'h0000_0000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Encoding reference: range rules as signed arithmetic, fields placed with shifts.
   function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] f_rd,
                                         input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                         input logic [2:0] f3, input logic [31:0] v);
      int signed   s;
      logic        ok;
      logic [31:0] w;
      s  = $signed(v);
      ok = 1'b0;
      w  = 32'(op) | (32'(f3) << 12) | (32'(f_rs1) << 15);
      case (op[6:5])
         2'b00: begin
            ok = (s >= -2048) && (s <= 2047);
            w  = w | ((v & 32'hFFF) << 20) | (32'(f_rd) << 7);
         end
         2'b01: begin
            ok = (s >= -2048) && (s <= 2047);
            w  = w | (((v >> 5) & 32'h7F) << 25) | (32'(f_rs2) << 20) | ((v & 32'h1F) << 7);
         end
         2'b11: begin
            ok = (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
            w  = w | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
                   | (32'(f_rs2) << 20) | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
         end
         default: ok = 1'b0;
      endcase
      if (!ok) return {1'b1, NOP};
      return {1'b0, w};
   endfunction

   // Core-side immediate decode, used to confirm each packed word round-trips.
   function automatic logic [31:0] decode_imm(input logic [31:0] w);
      case (w[6:5])
         2'b00:   return {{20{w[31]}}, w[31:20]};
         2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
         2'b11:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [32:0] m;
      if (reset) begin
         exp_q.delete();
         exp_err_q.delete();
         exp_imm_q.delete();
         m_addr  = BASE_ADDR;
         m_cnt   = 0;
         stalled = 1'b0;
         prev_clear = 1'b0;
      end else begin
         chk("err_count", 32'(err_count), 32'(m_cnt));
         if (stalled) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_instr", out_instr, st_instr);
            chk("stall_err", 32'(out_err), 32'(st_err));
            if (!prev_clear) chk("stall_addr", 32'(out_addr), 32'(st_addr));
         end
         stalled  = out_valid && !out_ready;
         st_instr = out_instr;
         st_addr  = out_addr;
         st_err   = out_err;
         if (out_valid && out_ready) begin
            chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               logic [31:0] e_w, e_imm;
               logic        e_err;
               e_w   = exp_q.pop_front();
               e_err = exp_err_q.pop_front();
               e_imm = exp_imm_q.pop_front();
               chk("sb_instr", out_instr, e_w);
               chk("sb_err", 32'(out_err), 32'(e_err));
               chk("sb_addr", 32'(out_addr), 32'(m_addr));
               if (!e_err) chk("sb_decode", decode_imm(out_instr), e_imm);
            end
            m_addr = (m_addr + 4) % (1 << ADDR_W);
            if (out_err && m_cnt < (1 << ERR_CNT_W) - 1) m_cnt = m_cnt + 1;
         end
         if (clear) begin
            m_addr = BASE_ADDR;
            m_cnt  = 0;
         end
         prev_clear = clear;
         if (in_valid && in_ready) begin
            m = model(opcode, rd, rs1, rs2, funct3, imm);
            exp_q.push_back(m[31:0]);
            exp_err_q.push_back(m[32]);
            exp_imm_q.push_back(imm);
            acc_cnt++;
         end
      end
   end

   // ---------------- driver tasks (entered at posedge+1) ----------------
   task automatic send(input logic [6:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                       input logic [4:0] f_rs2, input logic [2:0] f3, input logic [31:0] v);
      int n;
      opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; funct3 = f3; imm = v;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] w, input logic e, input logic [ADDR_W-1:0] a);
      @(negedge clk);
      chk("latency_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("dir_instr", out_instr, w);
      chk("dir_err", 32'(out_err), 32'(e));
      chk("dir_addr", 32'(out_addr), 32'(a));
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
         1:       v = $urandom;
         2:       v = edge_imm[$urandom_range(0, 9)];
         default: v = (32'($urandom_range(0, 4095)) << 1) - 32'd4096;
      endcase
      send({2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))}, 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), v);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int acc0;
      bit rnd_done;
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'(BASE_ADDR));
      chk("rst_err_count", 32'(err_count), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Basic formats, then two errored words.
      send(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'hFFFF_FFFC);
      expect_word(32'hFFC1_2283, 1'b0, 4'd0);
      send(7'b0100011, 5'd0, 5'd2, 5'd6, 3'b010, 32'd8);
      expect_word(32'h0061_2423, 1'b0, 4'd4);
      send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'hFFFF_FFF8);
      expect_word(32'hFE20_8CE3, 1'b0, 4'd8);
      send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'd5);
      expect_word(NOP, 1'b1, 4'd12);
      send(7'b0000011, 5'd1, 5'd1, 5'd0, 3'b000, 32'd2048);
      expect_word(NOP, 1'b1, 4'd0);
      chk("err_count_two", 32'(err_count), 32'd2);
      chk("addr_after_wrap", 32'(out_addr), 32'd4);

      // Clear coinciding with an output handshake.
      pulse_clear();
      send(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b000, 32'd1);
      expect_word(32'h0012_0193, 1'b0, 4'd0);
      send(7'b0010011, 5'd3, 5'd4, 5'd0, 3'b000, 32'd2);
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(negedge clk);
      chk("clr_hs_valid", 32'(out_valid), 32'd1);
      chk("clr_hs_addr", 32'(out_addr), 32'd4);
      @(posedge clk);
      #1;
      clear = 1'b0;
      chk("clr_hs_addr_after", 32'(out_addr), 32'(BASE_ADDR));
      chk("clr_hs_count", 32'(err_count), 32'd0);

      // Five back-to-back words wrap the 4-bit address, then clear.
      for (int i = 0; i < 5; i++) send(7'b0000011, 5'(i), 5'd1, 5'd0, 3'b010, 32'(i * 4));
      drain();
      chk("wrap_next_addr", 32'(out_addr), 32'd4);
      pulse_clear();
      chk("wrap_clear_addr", 32'(out_addr), 32'(BASE_ADDR));
      send(7'b0100011, 5'd0, 5'd3, 5'd7, 3'b001, 32'hFFFF_F800);
      expect_word(32'h8071_9023, 1'b0, 4'd0);

      // Stall: four requests, consumer blocked for five cycles.
      pulse_clear();
      out_ready = 1'b0;
      acc0 = acc_cnt;
      fork
         begin
            send(7'b0000011, 5'd1, 5'd2, 5'd0, 3'b000, 32'd16);
            send(7'b0100011, 5'd0, 5'd2, 5'd3, 3'b010, 32'hFFFF_FFF0);
            send(7'b1100011, 5'd0, 5'd4, 5'd5, 3'b001, 32'd4094);
            send(7'b1100011, 5'd0, 5'd6, 5'd7, 3'b101, 32'hFFFF_F000);
         end
         begin
            repeat (5) @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_accepts", 32'(acc_cnt - acc0), 32'd2);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_all_accepted", 32'(acc_cnt - acc0), 32'd4);
      chk("stall_end_addr", 32'(out_addr), 32'd0);

      // Error counter saturates.
      pulse_clear();
      for (int i = 0; i < 9; i++) send(7'b1000011, 5'd0, 5'd0, 5'd0, 3'b000, 32'(i));
      drain();
      chk("err_saturate", 32'(err_count), 32'((1 << ERR_CNT_W) - 1));

      // Asynchronous reset with two requests in flight.
      out_ready = 1'b0;
      send(7'b0000011, 5'd1, 5'd1, 5'd0, 3'b000, 32'd1);
      send(7'b0000011, 5'd2, 5'd2, 5'd0, 3'b000, 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(err_count), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      send(7'b0000011, 5'd9, 5'd8, 5'd0, 3'b100, 32'hFFFF_F800);
      expect_word(32'h8004_4483, 1'b0, 4'(BASE_ADDR));

      // Random traffic with random backpressure and occasional clears.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               rand_req();
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
               clear     = ($urandom_range(0, 29) == 0);
            end
            out_ready = 1'b1;
            clear     = 1'b0;
         end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
